// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: word request/acknowledge handshake.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch unit drives the request and address and receives the data
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction memory answers the request
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC, fetches one instruction word per request,
// holds it for the decoder, and selects the next PC from jump/branch/zero.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    input  logic                      jump,
    input  logic                      branch,
    input  logic                      zero,
    input  logic                      stall,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [5:0]                opcode,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = fetch_pc_q;
    assign instr_valid    = valid_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;

    assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Next-PC select: jump beats taken branch; decoder inputs only matter while an instruction is held
    always_comb begin
        next_pc = pc_plus4;
        if (valid_q) begin
            if (jump) begin
                next_pc = jump_target;
            end else if (branch && zero) begin
                next_pc = branch_target;
            end
        end
    end

    // Next-state and datapath update for the FETCH/EXEC sequencer
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        case (state_q)
            FETCH: begin
                // req stays low for the first cycle out of reset, so an ack then is ignored
                req_d = 1'b1;
                if (req_q && imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    pc_d    = fetch_pc_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    valid_d    = 1'b0;
                    req_d      = 1'b1;
                    fetch_pc_d = next_pc;
                    state_d    = FETCH;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            instr_q    <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch addresses and
// instruction words are queued as stimulus is driven and checked as the
// DUT presents them.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        jump, branch, zero, stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
        chk({tag, "_addr"},  bus.imem_addr, 32'h0000_0000);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_op"},    {26'd0, opcode}, 32'd0);
        chk({tag, "_pc"},    pc, 32'd0);
        chk({tag, "_pc4"},   pc_plus4, 32'd4);
    endtask

    // Wait for a request, check its address, hold for `waits` cycles, ack, check the presented instruction
    task automatic do_fetch(input logic [31:0] data, input int waits);
        int          n;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
        exp_addr = addr_q.pop_front();
        chk("fetch_addr", bus.imem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, exp_addr);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        instr_q.push_back(data);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        exp_instr = instr_q.pop_front();
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, exp_instr);
        chk("opcode", {26'd0, opcode}, {26'd0, exp_instr[31:26]});
        chk("pc", pc, exp_addr);
        chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
        chk("req_low", {31'd0, bus.imem_req}, 32'd0);
    endtask

    // Hold in EXEC for stall_n cycles, then release with the given decoder inputs
    task automatic exec(input logic j, input logic b, input logic z, input int stall_n,
                        input bit poke_ack, input logic [31:0] next);
        logic [31:0] i0;
        logic [31:0] p0;
        i0 = instr;
        p0 = pc;
        for (int i = 0; i < stall_n; i++) begin
            stall  = 1'b1;
            jump   = 1'b1;
            branch = 1'b1;
            zero   = 1'b1;
            if (poke_ack) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 32'hDEAD_0000 | i;
            end
            @(negedge clk);
            bus.imem_ack = 1'b0;
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, i0);
            chk("stall_op", {26'd0, opcode}, {26'd0, i0[31:26]});
            chk("stall_pc", pc, p0);
        end
        stall  = 1'b0;
        jump   = j;
        branch = b;
        zero   = z;
        addr_q.push_back(next);
        @(negedge clk);
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        chk("resume_req", {31'd0, bus.imem_req}, 32'd1);
        chk("resume_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] wait_addr;
        int          n;
        rst_n          = 1'b0;
        jump           = 1'b0;
        branch         = 1'b0;
        zero           = 1'b0;
        stall          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");

        // First fetch: zero-wait memory, then sequential
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0000_0000);
        addr_q.push_back(32'h0000_0000);
        do_fetch(32'h2008_0005, 0);
        chk("first_op", {26'd0, opcode}, 32'h08);
        exec(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0004);

        // Three wait states; ack pulses in EXEC ignored; jump to 0x40
        do_fetch(32'h0800_0010, 3);
        exec(1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0040);
        do_fetch(32'h0800_0010, 0);
        exec(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0040);
        do_fetch(32'h0800_0100, 1);
        exec(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0400);
        do_fetch(32'h0800_0040, 0);
        exec(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0100);

        // beq at 0x100, imm 0xFFFE: taken, not taken, jump+branch
        do_fetch(32'h1000_FFFE, 0);
        exec(1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h0000_00FC);
        do_fetch(32'h0800_0040, 2);
        exec(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0100);
        do_fetch(32'h1000_FFFE, 0);
        exec(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0000_0104);
        do_fetch(32'h0800_0040, 0);
        exec(1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h0000_0100);

        // Five-cycle stall, then sequential
        do_fetch(32'h1000_FFFE, 0);
        exec(1'b0, 1'b0, 1'b0, 5, 1'b0, 32'h0000_0104);

        // Reset pulsed mid-wait with an ack in flight
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        wait_addr = addr_q.pop_front();
        chk("midwait_addr", bus.imem_addr, wait_addr);
        @(negedge clk);
        chk("midwait_hold", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        rst_n          = 1'b0;
        #1;
        chk_reset_values("midreset");
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk_reset_values("midreset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'd0, bus.imem_req}, 32'd1);
        chk("restart_addr", bus.imem_addr, 32'h0000_0000);

        // Reach the top of the address space and wrap
        addr_q.push_back(32'h0000_0000);
        do_fetch(32'h1000_8000, 0);
        exec(1'b0, 1'b1, 1'b1, 0, 1'b0, 32'hFFFE_0004);
        do_fetch(32'h0BFF_FFFF, 0);
        exec(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'hFFFF_FFFC);
        do_fetch(32'h2008_0005, 1);
        chk("wrap_pc4", pc_plus4, 32'h0000_0000);
        exec(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0000);
        do_fetch(32'h0000_0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
